qlearn_step_sched: RTL and testbench
====================================

# qlearn_step_sched

Step scheduler for the Q-learning update pipeline. It runs a programmed number of episodes: each cycle it picks a pseudo-random action, presents `{state, action}` to the Q/R/next-state tables, and advances the current state. It tracks in-flight updates in a fixed-latency scoreboard and stalls issue on read-after-write hazards against the Q and Qmax tables. It sits between the host/config interface and the 4-stage update pipeline.

## Interface
- `S_BITS`, 6, state index width (64 states)
- `A_BITS`, 2, action index width (4 actions)
- `PIPE_DEPTH`, 4, cycles from issue to Q/Qmax writeback; scoreboard depth
- `CNT_BITS`, 16, episode/step counter width
- `i_clk`  in  1  clock; the block has one clock.
- `i_rst`  in  1  reset, synchronous, active-high
- `i_start`  in  1  pulse; sampled only in IDLE
- `i_num_episodes`  in  CNT_BITS  episodes to run; latched on start
- `i_max_steps`  in  CNT_BITS  step limit per episode; 0 is treated as 1; latched
- `i_start_state`  in  S_BITS  initial state of every episode; latched
- `i_term_state`  in  S_BITS  terminal state; latched
- `i_seed`  in  16  LFSR seed; latched
- `o_issue_addr`  out  S_BITS+A_BITS  `{state, action}`, i.e. s*4+a; always driven
- `o_issue_valid`  out  1  step issued this cycle
- `i_nexts`  in  S_BITS  next-state ROM output for `o_issue_addr`, combinational, same cycle
- `o_busy`  out  1  high in RUN or DRAIN
- `o_done`  out  1  one-cycle pulse when all episodes have retired
- `o_episode_cnt`  out  CNT_BITS  completed episodes
- `o_step_cnt`  out  CNT_BITS  steps issued in the current episode

## Operation
- FSM states: IDLE, RUN, DRAIN.
  - IDLE to RUN on `i_start`. If `i_num_episodes`==0, go to DRAIN instead.
  - RUN to DRAIN on the issue that completes the last episode.
  - DRAIN to IDLE when the scoreboard is empty; `o_done`=1 on that transition.
- Action source: 16-bit Fibonacci LFSR, taps 16,14,13,11. Action = `lfsr[A_BITS-1:0]`.
  - Loaded from `i_seed` on start; a seed of 0 is replaced by 16'hACE1.
  - Advances only on issue.
- Scoreboard: a PIPE_DEPTH shift register of `{valid, state}`. It shifts every cycle. On issue, the entry pushed is `{1, cur_state}`; otherwise `{0, x}` is pushed.
- Hazard: true if any valid scoreboard entry has state == `cur_state` (Q read) or == `i_nexts` (Qmax read).
  - `o_issue_valid` = RUN && !hazard.
  - During a stall, the state, LFSR and counters hold; the address stays stable.
- On issue:
  - `step_cnt`++.
  - If `i_nexts`==term or step_cnt+1 == max_steps, the episode ends: `cur_state` ← start_state, `step_cnt` ← 0, `episode_cnt`++.
  - Otherwise `cur_state` ← `i_nexts`.
- `i_start` is ignored outside IDLE. Configuration changes after start have no effect.
- All counters are CNT_BITS wide and never wrap inside a run; the bound is the latched limits.

## Timing
- Reset values: FSM=IDLE, all outputs 0, scoreboard cleared, LFSR=16'hACE1, `cur_state`=0.
- `i_rst` mid-run abandons the run immediately, with no `o_done` and no drain. The pipeline owner discards in-flight writes.
- Start at cycle t gives the first `o_issue_valid` at t+1, with addr = `{start_state, lfsr[1:0]}`.
- An issue at cycle t retires (leaves the scoreboard) at t+PIPE_DEPTH. A stalled step can issue no earlier than t+PIPE_DEPTH.
- Throughput is 1 step/cycle when there is no hazard.
- A self-loop (`i_nexts`==`cur_state`) or an immediate return to a recent state stalls up to PIPE_DEPTH cycles.
- `o_done` is asserted PIPE_DEPTH cycles after the last issue if there was no stall before the drain. `o_busy` falls in the same cycle `o_done` pulses.
- Zero-episode start: DRAIN at t+1, `o_done` at t+1, nothing issued.

## Structure
- Package `qlearn_pkg` holds:
  - the `S_BITS`/`A_BITS` defaults;
  - the LFSR tap mask and the 16'hACE1 fallback seed;
  - the FSM state enum;
  - a typedef for the `{valid, state}` scoreboard entry.
- Sub-module `qlearn_lfsr`: 16-bit LFSR with load/enable. The scheduler instantiates it once.
- Scoreboard and hazard compare stay inline, as a PIPE_DEPTH-way equality OR.

## Test plan
- Chain 0→1→2→…, term=5, max_steps=100, 1 episode, seed 1 → 5 back-to-back issues with no stall; `o_done` 4 cycles after the last issue; `episode_cnt`=1.
- Self-loop ROM (nexts=s), max_steps=3 → issues spaced 4 cycles apart; episode ends after 3 issues; state resets to start.
- Two-state ping-pong 0↔1, PIPE_DEPTH=4 → stall whenever the matching state is in flight; LFSR and address frozen during stalls; sequence matches a golden model.
- `i_num_episodes`=0 → no issue; `o_done` one cycle after start. `i_max_steps`=0 → every episode is 1 step.
- Assert `i_rst` mid-run with 3 entries in flight → next cycle IDLE, outputs 0, no `o_done`; restart behaves identically to a fresh run.
- `i_start` pulsed during RUN → ignored; counts unchanged.

Source files
------------

// File: rtl/qlearn_step_sched_pkg.sv
// Shared types and constants for the Q-learning step scheduler.
package qlearn_pkg;

    localparam int unsigned S_BITS_DEF    = 6;
    localparam int unsigned A_BITS_DEF    = 2;
    // Scoreboard entries carry a state field wide enough for any S_BITS up to 16.
    localparam int unsigned SB_STATE_W    = 16;

    // Fibonacci taps 16,14,13,11 -> bits 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS     = 16'hB400;
    localparam logic [15:0] LFSR_FALLBACK = 16'hACE1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } sched_state_e;

    typedef struct packed {
        logic                  valid;
        logic [SB_STATE_W-1:0] state;
    } sb_entry_t;

endpackage

// File: rtl/qlearn_step_sched_if.sv
// Host/config, table-issue and status signals of the step scheduler.
interface qlearn_step_sched_if #(
    parameter int unsigned S_BITS   = 6,
    parameter int unsigned A_BITS   = 2,
    parameter int unsigned CNT_BITS = 16
);
    logic                     i_start;
    logic [CNT_BITS-1:0]      i_num_episodes;
    logic [CNT_BITS-1:0]      i_max_steps;
    logic [S_BITS-1:0]        i_start_state;
    logic [S_BITS-1:0]        i_term_state;
    logic [15:0]              i_seed;
    logic [S_BITS+A_BITS-1:0] o_issue_addr;
    logic                     o_issue_valid;
    logic [S_BITS-1:0]        i_nexts;
    logic                     o_busy;
    logic                     o_done;
    logic [CNT_BITS-1:0]      o_episode_cnt;
    logic [CNT_BITS-1:0]      o_step_cnt;

    // Host / table side
    modport master (
        output i_start, i_num_episodes, i_max_steps, i_start_state,
               i_term_state, i_seed, i_nexts,
        input  o_issue_addr, o_issue_valid, o_busy, o_done,
               o_episode_cnt, o_step_cnt
    );

    // Scheduler side
    modport slave (
        input  i_start, i_num_episodes, i_max_steps, i_start_state,
               i_term_state, i_seed, i_nexts,
        output o_issue_addr, o_issue_valid, o_busy, o_done,
               o_episode_cnt, o_step_cnt
    );
endinterface

// File: rtl/qlearn_step_sched_lfsr.sv
// 16-bit Fibonacci LFSR with synchronous load and advance enable.
module qlearn_lfsr
    import qlearn_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load,
    input  logic        i_en,
    input  logic [15:0] i_seed,
    output logic [15:0] o_lfsr
);
    logic [15:0] lfsr_q, lfsr_d;

    // Load takes priority over advance; an all-zero seed would lock up.
    always_comb begin
        lfsr_d = lfsr_q;
        if (i_load) begin
            lfsr_d = (i_seed == '0) ? LFSR_FALLBACK : i_seed;
        end else if (i_en) begin
            lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) lfsr_q <= LFSR_FALLBACK;
        else       lfsr_q <= lfsr_d;
    end

    assign o_lfsr = lfsr_q;
endmodule

// File: rtl/qlearn_step_sched.sv
// Step scheduler: issues {state, action} steps, tracks in-flight updates,
// and stalls on Q/Qmax read-after-write hazards.
module qlearn_step_sched
    import qlearn_pkg::*;
#(
    parameter int unsigned S_BITS     = S_BITS_DEF,
    parameter int unsigned A_BITS     = A_BITS_DEF,
    parameter int unsigned PIPE_DEPTH = 4,
    parameter int unsigned CNT_BITS   = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    qlearn_step_sched_if.slave bus
);
    // The entry issued PIPE_DEPTH cycles ago writes back this cycle, so only
    // the PIPE_DEPTH-1 younger entries can still block a read.
    localparam int unsigned SB_N = PIPE_DEPTH - 1;

    sched_state_e        state_q, state_d;
    logic [S_BITS-1:0]   cur_state_q, cur_state_d;
    logic [S_BITS-1:0]   start_state_q, start_state_d;
    logic [S_BITS-1:0]   term_state_q, term_state_d;
    logic [CNT_BITS-1:0] step_cnt_q, step_cnt_d;
    logic [CNT_BITS-1:0] episode_cnt_q, episode_cnt_d;
    logic [CNT_BITS-1:0] num_ep_q, num_ep_d;
    logic [CNT_BITS-1:0] max_steps_q, max_steps_d;
    sb_entry_t           sb_q [SB_N];
    sb_entry_t           sb_d [SB_N];

    logic [15:0] lfsr;
    logic        start_acc, issue, hazard, sb_empty, ep_end, last_ep;

    qlearn_lfsr u_lfsr (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (start_acc),
        .i_en   (issue),
        .i_seed (bus.i_seed),
        .o_lfsr (lfsr)
    );

    assign start_acc = (state_q == ST_IDLE) && bus.i_start;
    assign issue     = (state_q == ST_RUN) && !hazard;
    assign ep_end    = (bus.i_nexts == term_state_q) ||
                       ((step_cnt_q + CNT_BITS'(1)) == max_steps_q);
    assign last_ep   = (episode_cnt_q + CNT_BITS'(1)) == num_ep_q;

    assign bus.o_issue_addr = (state_q == ST_IDLE) ? '0 : {cur_state_q, lfsr[A_BITS-1:0]};

    // Hazard: any live entry matching the Q read (cur) or Qmax read (nexts).
    always_comb begin
        hazard   = 1'b0;
        sb_empty = 1'b1;
        for (int unsigned i = 0; i < SB_N; i++) begin
            if (sb_q[i].valid) begin
                sb_empty = 1'b0;
                if ((sb_q[i].state == SB_STATE_W'(cur_state_q)) ||
                    (sb_q[i].state == SB_STATE_W'(bus.i_nexts))) begin
                    hazard = 1'b1;
                end
            end
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start_acc) state_d = (bus.i_num_episodes == '0) ? ST_DRAIN : ST_RUN;
            ST_RUN:   if (issue && ep_end && last_ep) state_d = ST_DRAIN;
            ST_DRAIN: if (sb_empty) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        bus.o_issue_valid = issue;
        bus.o_busy        = (state_q != ST_IDLE);
        bus.o_done        = (state_q == ST_DRAIN) && sb_empty;
        bus.o_episode_cnt = episode_cnt_q;
        bus.o_step_cnt    = step_cnt_q;
    end

    // Datapath next values: config latch, state/counter advance, scoreboard shift.
    always_comb begin
        cur_state_d   = cur_state_q;
        start_state_d = start_state_q;
        term_state_d  = term_state_q;
        step_cnt_d    = step_cnt_q;
        episode_cnt_d = episode_cnt_q;
        num_ep_d      = num_ep_q;
        max_steps_d   = max_steps_q;

        sb_d[0].valid = issue;
        sb_d[0].state = SB_STATE_W'(cur_state_q);
        for (int unsigned i = 1; i < SB_N; i++) sb_d[i] = sb_q[i-1];

        if (start_acc) begin
            num_ep_d      = bus.i_num_episodes;
            max_steps_d   = (bus.i_max_steps == '0) ? CNT_BITS'(1) : bus.i_max_steps;
            start_state_d = bus.i_start_state;
            term_state_d  = bus.i_term_state;
            cur_state_d   = bus.i_start_state;
            step_cnt_d    = '0;
            episode_cnt_d = '0;
        end else if (issue) begin
            if (ep_end) begin
                cur_state_d   = start_state_q;
                step_cnt_d    = '0;
                episode_cnt_d = episode_cnt_q + CNT_BITS'(1);
            end else begin
                cur_state_d   = bus.i_nexts;
                step_cnt_d    = step_cnt_q + CNT_BITS'(1);
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cur_state_q   <= '0;
            start_state_q <= '0;
            term_state_q  <= '0;
            step_cnt_q    <= '0;
            episode_cnt_q <= '0;
            num_ep_q      <= '0;
            max_steps_q   <= '0;
            for (int unsigned i = 0; i < SB_N; i++) sb_q[i] <= '0;
        end else begin
            cur_state_q   <= cur_state_d;
            start_state_q <= start_state_d;
            term_state_q  <= term_state_d;
            step_cnt_q    <= step_cnt_d;
            episode_cnt_q <= episode_cnt_d;
            num_ep_q      <= num_ep_d;
            max_steps_q   <= max_steps_d;
            sb_q          <= sb_d;
        end
    end
endmodule

// File: tb/tb_qlearn_step_sched.sv
// Self-checking bench for qlearn_step_sched against a cycle-level behavioural model.
module tb_qlearn_step_sched;
    localparam int unsigned S_BITS = 6;
    localparam int unsigned A_BITS = 2;
    localparam int unsigned PD     = 4;
    localparam int unsigned CNT    = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    qlearn_step_sched_if #(.S_BITS(S_BITS), .A_BITS(A_BITS), .CNT_BITS(CNT)) bus ();

    qlearn_step_sched #(
        .S_BITS(S_BITS), .A_BITS(A_BITS), .PIPE_DEPTH(PD), .CNT_BITS(CNT)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    // Next-state ROM seen by the scheduler.
    logic [S_BITS-1:0] rom [256];
    assign bus.i_nexts = rom[bus.o_issue_addr];

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;

    // Behavioural model
    bit          m_run, m_drain;
    int unsigned m_cur, m_step, m_ep, m_num, m_max, m_start, m_term, m_cycle;
    logic [15:0] m_lfsr;
    typedef struct { int unsigned st; int unsigned t; } flight_t;
    flight_t inflight [$];

    // Observations
    int unsigned issues_seen, last_issue, done_cyc, done_seen, start_cyc;
    bit          have_last, chk_spacing;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        logic fb;
        fb = l[15] ^ l[13] ^ l[12] ^ l[10];
        return 16'((32'(l) * 2) % 65536) | {15'd0, fb};
    endfunction

    task automatic model_reset();
        m_run = 0; m_drain = 0; m_cur = 0; m_step = 0; m_ep = 0;
        m_lfsr = 16'hACE1;
        inflight.delete();
    endtask

    // One clock cycle: compare outputs against the model, then advance the model.
    task automatic tick();
        int unsigned addr_e, nx;
        bit haz, v_e, done_e;
        #1;
        while (inflight.size() > 0 && (m_cycle - inflight[0].t) >= PD) void'(inflight.pop_front());
        addr_e = (m_run || m_drain) ? (m_cur * 4 + int'(m_lfsr % 4)) : 0;
        nx     = int'(rom[addr_e]);
        haz    = 0;
        foreach (inflight[i]) if (inflight[i].st == m_cur || inflight[i].st == nx) haz = 1;
        v_e    = m_run && !haz;
        done_e = m_drain && (inflight.size() == 0);

        chk("issue_valid", 32'(bus.o_issue_valid), 32'(v_e));
        chk("issue_addr",  32'(bus.o_issue_addr),  addr_e);
        chk("busy",        32'(bus.o_busy),        32'(m_run || m_drain));
        chk("done",        32'(bus.o_done),        32'(done_e));
        chk("episode_cnt", 32'(bus.o_episode_cnt), m_ep);
        chk("step_cnt",    32'(bus.o_step_cnt),    m_step);

        if (bus.o_issue_valid) begin
            if (chk_spacing && have_last) chk("issue_spacing", m_cycle - last_issue, PD);
            have_last  = 1;
            last_issue = m_cycle;
            issues_seen++;
        end
        if (bus.o_done) begin
            done_cyc = m_cycle;
            done_seen++;
        end

        if (rst) begin
            model_reset();
        end else if (!m_run && !m_drain) begin
            if (bus.i_start) begin
                m_num   = int'(bus.i_num_episodes);
                m_max   = (bus.i_max_steps == 0) ? 1 : int'(bus.i_max_steps);
                m_start = int'(bus.i_start_state);
                m_term  = int'(bus.i_term_state);
                m_lfsr  = (bus.i_seed == 0) ? 16'hACE1 : bus.i_seed;
                m_cur   = m_start; m_step = 0; m_ep = 0;
                if (m_num == 0) m_drain = 1; else m_run = 1;
            end
        end else if (m_run) begin
            if (v_e) begin
                inflight.push_back('{st: m_cur, t: m_cycle});
                m_lfsr = lfsr_step(m_lfsr);
                if (nx == m_term || m_step + 1 == m_max) begin
                    m_cur = m_start; m_step = 0; m_ep++;
                    if (m_ep == m_num) begin m_run = 0; m_drain = 1; end
                end else begin
                    m_cur = nx; m_step++;
                end
            end
        end else if (done_e) begin
            m_drain = 0;
        end
        m_cycle++;
        @(negedge clk);
    endtask

    // Start a run, scramble config afterwards, optionally poke i_start mid-run.
    task automatic run(input int unsigned num, input int unsigned max, input int unsigned st,
                       input int unsigned term, input logic [15:0] seed,
                       input int unsigned poke, input int unsigned budget);
        int unsigned n;
        bus.i_num_episodes = CNT'(num);
        bus.i_max_steps    = CNT'(max);
        bus.i_start_state  = S_BITS'(st);
        bus.i_term_state   = S_BITS'(term);
        bus.i_seed         = seed;
        issues_seen = 0; have_last = 0; done_seen = 0;
        start_cyc = m_cycle;
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        bus.i_num_episodes = CNT'($urandom);
        bus.i_max_steps    = CNT'($urandom);
        bus.i_start_state  = S_BITS'($urandom);
        bus.i_term_state   = S_BITS'($urandom);
        bus.i_seed         = 16'($urandom);
        n = 0;
        while ((m_run || m_drain) && n < budget) begin
            if (poke != 0 && n == poke) bus.i_start = 1'b1;
            tick();
            bus.i_start = 1'b0;
            n++;
        end
        chk("run_in_budget", 32'(m_run || m_drain), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n;
        rst = 1'b1;
        bus.i_start = 1'b0; bus.i_num_episodes = '0; bus.i_max_steps = '0;
        bus.i_start_state = '0; bus.i_term_state = '0; bus.i_seed = '0;
        for (int i = 0; i < 256; i++) rom[i] = '0;
        chk_spacing = 0;
        repeat (2) @(negedge clk);
        model_reset();
        m_cycle = 0;
        rst = 1'b0;
        tick();                                  // reset state

        // Linear chain 0->1->..., terminal 5
        for (int i = 0; i < 256; i++) rom[i] = S_BITS'(i / 4 + 1);
        run(1, 100, 0, 5, 16'h0001, 0, 60);
        chk("chain_issues", issues_seen, 5);
        chk("chain_done_lat", done_cyc - last_issue, PD);
        chk("chain_episodes", 32'(bus.o_episode_cnt), 1);

        // Self-loop: every issue blocks the next for PIPE_DEPTH cycles
        for (int i = 0; i < 256; i++) rom[i] = S_BITS'(i / 4);
        chk_spacing = 1;
        run(2, 3, 7, 63, 16'h1234, 0, 100);
        chk_spacing = 0;
        chk("selfloop_issues", issues_seen, 6);

        // Ping-pong 0 <-> 1
        for (int i = 0; i < 256; i++) rom[i] = (i < 4) ? 6'd1 : ((i < 8) ? 6'd0 : 6'd2);
        run(2, 5, 0, 63, 16'($urandom), 0, 200);
        chk("pingpong_issues", issues_seen, 10);

        // Zero episodes
        run(0, 5, 3, 9, 16'h00FF, 0, 20);
        chk("zero_ep_issues", issues_seen, 0);
        chk("zero_ep_done_lat", done_cyc - start_cyc, 1);

        // max_steps = 0 behaves as 1; terminal unreachable; zero seed
        for (int i = 0; i < 256; i++) rom[i] = S_BITS'($urandom_range(0, 62));
        run(4, 0, 10, 63, 16'h0000, 0, 80);
        chk("maxsteps0_issues", issues_seen, 4);

        // i_start pulsed during RUN is ignored
        for (int i = 0; i < 256; i++) rom[i] = S_BITS'(i / 4 + 1);
        run(2, 6, 20, 63, 16'hBEEF, 3, 100);
        chk("poke_issues", issues_seen, 12);

        // Reset with three updates in flight
        bus.i_num_episodes = 16'd1; bus.i_max_steps = 16'd100;
        bus.i_start_state = 6'd0; bus.i_term_state = 6'd40; bus.i_seed = 16'h5A5A;
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        n = 0;
        while (inflight.size() < 3 && n < 20) begin tick(); n++; end
        chk("inflight_at_reset", inflight.size(), 3);
        done_seen = 0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (6) tick();
        chk("reset_busy", 32'(bus.o_busy), 0);
        chk("reset_no_done", done_seen, 0);
        run(1, 100, 0, 40, 16'h5A5A, 0, 100);
        chk("restart_issues", issues_seen, 40);

        // Randomized runs
        for (int r = 0; r < 8; r++) begin
            int unsigned ne, ms;
            for (int i = 0; i < 256; i++) rom[i] = S_BITS'($urandom);
            ne = $urandom_range(1, 3);
            ms = $urandom_range(0, 12);
            run(ne, ms, $urandom_range(0, 63), $urandom_range(0, 63),
                16'($urandom), $urandom_range(0, 6), ne * (ms + 1) * (PD + 1) + 20);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
